// File: rtl/lvds_io_ctrl_sequencer_if.sv
// Signal bundle between the LVDS control PIO (master) and the LVDS I/O sequencer (slave).
// Carries the request word and the pin/status outputs.
interface lvds_io_ctrl_sequencer_if;
  logic [3:0] ctrl_in;
  logic       lvds_pwdn_n;
  logic       lvds_tx_en;
  logic       lvds_rx_en;
  logic       lvds_preemph;
  logic       ready;
  logic       busy;
  logic [2:0] state_out;
  logic [3:0] applied_out;

  modport master (
    output ctrl_in,
    input  lvds_pwdn_n, lvds_tx_en, lvds_rx_en, lvds_preemph,
    input  ready, busy, state_out, applied_out
  );

  modport slave (
    input  ctrl_in,
    output lvds_pwdn_n, lvds_tx_en, lvds_rx_en, lvds_preemph,
    output ready, busy, state_out, applied_out
  );
endinterface

// File: rtl/lvds_io_ctrl_sequencer.sv
// Sequences LVDS transceiver power-up, power-down and pre-emphasis changes from a 4-bit PIO word.
// Optional macro LVDS_CTRL_SYNC_EN adds a 2-flop synchronizer ahead of the request register.
module lvds_io_ctrl_sequencer #(
  parameter int T_PWRUP   = 5000,
  parameter int T_DISABLE = 16,
  parameter int T_GAP     = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  lvds_io_ctrl_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_PWRUP   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_RECFG   = 3'd3,
    S_DISABLE = 3'd4
  } state_t;

  localparam logic [3:0] CTRL_RST = 4'b0100;

  // A zero duration still spends one cycle in the state.
  localparam logic [CNT_W-1:0] LD_PWRUP   = (T_PWRUP   < 1) ? CNT_W'(1) : CNT_W'(T_PWRUP);
  localparam logic [CNT_W-1:0] LD_DISABLE = (T_DISABLE < 1) ? CNT_W'(1) : CNT_W'(T_DISABLE);
  localparam logic [CNT_W-1:0] LD_GAP     = (T_GAP     < 1) ? CNT_W'(1) : CNT_W'(T_GAP);

  logic [3:0]       ctrl_src, ctrl_q;
  state_t           state, state_d;
  logic [CNT_W-1:0] timer, timer_d, timer_dec;
  logic             expired;
  logic             pwdn_n, pwdn_n_d;
  logic             tx_en, tx_d;
  logic             rx_en, rx_d;
  logic             preemph, pre_d;
  logic             ready_q, busy_q;

`ifdef LVDS_CTRL_SYNC_EN
  logic [3:0] sync_1, sync_2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= CTRL_RST;
      sync_2 <= CTRL_RST;
    end else begin
      sync_1 <= bus.ctrl_in;
      sync_2 <= sync_1;
    end
  end

  assign ctrl_src = sync_2;
`else
  assign ctrl_src = bus.ctrl_in;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= CTRL_RST;
      state   <= S_OFF;
      timer   <= '0;
      pwdn_n  <= 1'b0;
      tx_en   <= 1'b0;
      rx_en   <= 1'b0;
      preemph <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_src;
      state   <= state_d;
      timer   <= timer_d;
      pwdn_n  <= pwdn_n_d;
      tx_en   <= tx_d;
      rx_en   <= rx_d;
      preemph <= pre_d;
      ready_q <= (state_d == S_ACTIVE);
      busy_q  <= (state_d == S_PWRUP) || (state_d == S_RECFG) || (state_d == S_DISABLE);
    end
  end

  // Saturating down-count: the timer is reloaded only on state entry and never wraps.
  assign timer_dec = (timer != '0) ? timer - CNT_W'(1) : timer;
  assign expired   = (timer <= CNT_W'(1));

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    pwdn_n_d = pwdn_n;
    tx_d     = tx_en;
    rx_d     = rx_en;
    pre_d    = preemph;

    case (state)
      S_OFF: begin
        pwdn_n_d = 1'b0;
        tx_d     = 1'b0;
        rx_d     = 1'b0;
        pre_d    = ctrl_q[3];
        if (!ctrl_q[2]) begin
          state_d  = S_PWRUP;
          pwdn_n_d = 1'b1;
          timer_d  = LD_PWRUP;
        end
      end

      S_PWRUP: begin
        tx_d = 1'b0;
        rx_d = 1'b0;
        if (ctrl_q[2]) begin
          state_d  = S_OFF;
          pwdn_n_d = 1'b0;
        end else if (expired) begin
          state_d = S_ACTIVE;
          tx_d    = ctrl_q[0];
          rx_d    = ctrl_q[1];
        end else begin
          timer_d = timer_dec;
        end
      end

      S_ACTIVE: begin
        if (ctrl_q[2]) begin
          state_d = S_DISABLE;
          tx_d    = 1'b0;
          rx_d    = 1'b0;
          timer_d = LD_DISABLE;
        end else if ((ctrl_q[3] != preemph) && tx_en) begin
          // Driver is live: blank TX before touching pre-emphasis.
          state_d = S_RECFG;
          tx_d    = 1'b0;
          rx_d    = ctrl_q[1];
          timer_d = LD_GAP;
        end else begin
          tx_d  = ctrl_q[0];
          rx_d  = ctrl_q[1];
          pre_d = ctrl_q[3];
        end
      end

      S_RECFG: begin
        tx_d  = 1'b0;
        rx_d  = ctrl_q[1];
        pre_d = ctrl_q[3];
        if (ctrl_q[2]) begin
          state_d = S_DISABLE;
          rx_d    = 1'b0;
          timer_d = LD_DISABLE;
        end else if (expired) begin
          state_d = S_ACTIVE;
          tx_d    = ctrl_q[0];
        end else begin
          timer_d = timer_dec;
        end
      end

      S_DISABLE: begin
        tx_d = 1'b0;
        rx_d = 1'b0;
        if (expired) begin
          state_d  = S_OFF;
          pwdn_n_d = 1'b0;
        end else begin
          timer_d = timer_dec;
        end
      end

      default: begin
        state_d  = S_OFF;
        pwdn_n_d = 1'b0;
        tx_d     = 1'b0;
        rx_d     = 1'b0;
      end
    endcase
  end

  assign bus.lvds_pwdn_n  = pwdn_n;
  assign bus.lvds_tx_en   = tx_en;
  assign bus.lvds_rx_en   = rx_en;
  assign bus.lvds_preemph = preemph;
  assign bus.ready        = ready_q;
  assign bus.busy         = busy_q;
  assign bus.state_out    = state;
  assign bus.applied_out  = {preemph, ~pwdn_n, rx_en, tx_en};

endmodule

// File: tb/tb_lvds_io_ctrl_sequencer.sv
// Self-checking bench for lvds_io_ctrl_sequencer: directed request sequence, a phase/age
// reference model compared every cycle, and literal spot checks at key cycles.
module tb_lvds_io_ctrl_sequencer;
  localparam int TP = 10;
  localparam int TD = 4;
  localparam int TG = 3;

  localparam int M_OFF = 0, M_PWRUP = 1, M_ACTIVE = 2, M_RECFG = 3, M_DIS = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  lvds_io_ctrl_sequencer_if bif ();

  lvds_io_ctrl_sequencer #(
    .T_PWRUP  (TP),
    .T_DISABLE(TD),
    .T_GAP    (TG),
    .CNT_W    (16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: current phase plus cycles spent in it, driven by the request seen one cycle late.
  logic [3:0] m_q, m_req;
  int         m_mode, m_age;
  logic       m_tx, m_rx, m_pre;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q = 4'b0100; m_mode = M_OFF; m_age = 0;
      m_tx = 1'b0; m_rx = 1'b0; m_pre = 1'b0;
    end else begin
      m_req = m_q;
      m_q   = bif.ctrl_in;
      case (m_mode)
        M_OFF: begin
          m_pre = m_req[3];
          if (!m_req[2]) begin m_mode = M_PWRUP; m_age = 1; end
        end
        M_PWRUP: begin
          if (m_req[2]) m_mode = M_OFF;
          else if (m_age == TP) begin m_mode = M_ACTIVE; m_tx = m_req[0]; m_rx = m_req[1]; end
          else m_age++;
        end
        M_ACTIVE: begin
          if (m_req[2]) begin m_mode = M_DIS; m_age = 1; m_tx = 1'b0; m_rx = 1'b0; end
          else if (m_req[3] != m_pre && m_tx) begin
            m_mode = M_RECFG; m_age = 1; m_tx = 1'b0; m_rx = m_req[1];
          end else begin m_pre = m_req[3]; m_tx = m_req[0]; m_rx = m_req[1]; end
        end
        M_RECFG: begin
          m_pre = m_req[3];
          m_rx  = m_req[1];
          if (m_req[2]) begin m_mode = M_DIS; m_age = 1; m_rx = 1'b0; end
          else if (m_age == TG) begin m_mode = M_ACTIVE; m_tx = m_req[0]; end
          else m_age++;
        end
        default: begin
          if (m_age == TD) m_mode = M_OFF;
          else m_age++;
        end
      endcase
    end
  end

  logic [15:0] exp_vec, act_vec;
  always_comb begin
    exp_vec = {3'b000, 3'(m_mode), (m_mode != M_OFF), m_tx, m_rx, m_pre,
               (m_mode == M_ACTIVE), (m_mode == M_PWRUP || m_mode == M_RECFG || m_mode == M_DIS),
               m_pre, (m_mode == M_OFF), m_rx, m_tx};
    act_vec = {3'b000, bif.state_out, bif.lvds_pwdn_n, bif.lvds_tx_en, bif.lvds_rx_en,
               bif.lvds_preemph, bif.ready, bif.busy, bif.applied_out};
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("model", act_vec, exp_vec);
      assert (!((bif.lvds_tx_en || bif.lvds_rx_en) && !bif.lvds_pwdn_n))
        else begin
          n_errors++;
          $display("FAIL invariant: enable high while powered down (t=%0t)", $time);
        end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    bif.ctrl_in = 4'b0100;
    step(3);
    check("rst_applied", 16'(bif.applied_out), 16'h4);
    check("rst_pins", 16'({bif.lvds_pwdn_n, bif.lvds_tx_en, bif.lvds_rx_en, bif.lvds_preemph,
                           bif.ready, bif.busy}), 16'h0);
    reset_n = 1'b1;
    step(5);
    check("off_state", 16'(bif.state_out), 16'h0);
    check("off_applied", 16'(bif.applied_out), 16'h4);

    // Power-up to ACTIVE with both enables requested.
    bif.ctrl_in = 4'b0011;
    step(1);  check("pu_latency", 16'(bif.lvds_pwdn_n), 16'h0);
    step(1);  check("pu_entry", 16'({bif.state_out, bif.lvds_pwdn_n, bif.busy}), 16'b1_1_1);
    step(9);  check("pu_last", 16'({bif.state_out, bif.lvds_tx_en}), 16'b001_0);
    step(1);  check("pu_active", 16'({bif.state_out, bif.ready, bif.applied_out}), 16'b010_1_0011);

    // Power-down through DISABLE.
    bif.ctrl_in = 4'b0111;
    step(2);  check("dis_entry", 16'({bif.state_out, bif.lvds_pwdn_n, bif.lvds_tx_en, bif.lvds_rx_en}), 16'b100_1_0_0);
    step(3);  check("dis_last", 16'({bif.state_out, bif.lvds_pwdn_n}), 16'b100_1);
    step(1);  check("dis_off", 16'({bif.state_out, bif.lvds_pwdn_n}), 16'b000_0);

    // Abort power-up on its 5th cycle.
    bif.ctrl_in = 4'b0011;
    step(5);
    bif.ctrl_in = 4'b0111;
    step(1);  check("abort_pre", 16'(bif.state_out), 16'h1);
    step(1);  check("abort_off", 16'({bif.state_out, bif.lvds_pwdn_n}), 16'b000_0);
    step(3);  check("abort_stay", 16'({bif.state_out, bif.lvds_tx_en, bif.lvds_rx_en}), 16'b000_0_0);

    // Pre-emphasis reconfiguration with TX live.
    bif.ctrl_in = 4'b0011;
    step(12); check("pu2_active", 16'({bif.state_out, bif.lvds_tx_en}), 16'b010_1);
    bif.ctrl_in = 4'b1011;
    step(1);  check("rc_latency", 16'({bif.state_out, bif.lvds_tx_en}), 16'b010_1);
    step(1);  check("rc_cyc1", 16'({bif.state_out, bif.lvds_tx_en, bif.lvds_rx_en, bif.lvds_preemph}), 16'b011_0_1_0);
    step(1);  check("rc_cyc2", 16'({bif.lvds_tx_en, bif.lvds_rx_en, bif.lvds_preemph}), 16'b0_1_1);
    step(1);  check("rc_cyc3", 16'({bif.state_out, bif.lvds_tx_en}), 16'b011_0);
    step(1);  check("rc_done", 16'({bif.state_out, bif.applied_out}), 16'b010_1011);

    // Power-down and pre-emphasis change together: DISABLE wins, preemph held until OFF.
    bif.ctrl_in = 4'b0111;
    step(2);  check("pri_entry", 16'({bif.state_out, bif.lvds_preemph, bif.lvds_tx_en}), 16'b100_1_0);
    step(3);  check("pri_hold", 16'({bif.lvds_preemph, bif.lvds_pwdn_n}), 16'b1_1);
    step(1);  check("pri_off", 16'({bif.state_out, bif.lvds_preemph, bif.lvds_pwdn_n}), 16'b000_1_0);
    step(1);  check("pri_follow", 16'(bif.lvds_preemph), 16'h0);

    // Pre-emphasis changes directly while TX is off; enables track requests.
    bif.ctrl_in = 4'b0010;
    step(12); check("rx_only", 16'({bif.state_out, bif.applied_out}), 16'b010_0010);
    bif.ctrl_in = 4'b1010;
    step(2);  check("pre_direct", 16'({bif.state_out, bif.lvds_preemph, bif.busy}), 16'b010_1_0);
    bif.ctrl_in = 4'b1001;
    step(2);  check("track", 16'(bif.applied_out), 16'b1001);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
